// File: rtl/button_debounce.sv
// button_debounce: per-button two-flop synchronizer plus stability counter.
// Raw pmod buttons are active-low; all outputs are active-high and registered.
// Optional feature macro: BUTTON_DEBOUNCE_RELEASE_PULSE_EN enables the
// release_pulse strobe; without it release_pulse is tied to zero.
module button_debounce #(
   parameter int unsigned N_BTN           = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
   input  logic             clk,
   input  logic             rst_btn,
   input  logic [N_BTN-1:0] pmod,
   output logic [N_BTN-1:0] pressed,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse
);

   localparam int unsigned    CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic [N_BTN-1:0] s1;
   logic [N_BTN-1:0] s2;
   logic [N_BTN-1:0] accept;
   logic [CW-1:0]    cnt [N_BTN];

   // Synchronizer; inverting at the input makes s1/s2 active-high.
   always_ff @(posedge clk) begin
      if (!rst_btn) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= ~pmod;
         s2 <= s1;
      end
   end

   // A new level is accepted on the cycle its run reaches the terminal count.
   always_comb begin
      accept = '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         accept[i] = (s2[i] != pressed[i]) && (cnt[i] == TERM);
      end
   end

   // Stability counters: any cycle agreeing with pressed restarts the run.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
         if (!rst_btn) begin
            cnt[i] <= '0;
         end else if ((s2[i] == pressed[i]) || accept[i]) begin
            cnt[i] <= '0;
         end else begin
            cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   // Debounced level and press strobe, updated together on acceptance.
   always_ff @(posedge clk) begin
      if (!rst_btn) begin
         pressed     <= '0;
         press_pulse <= '0;
      end else begin
         pressed     <= pressed ^ accept;
         press_pulse <= accept & s2;
      end
   end

`ifdef BUTTON_DEBOUNCE_RELEASE_PULSE_EN
   // Release strobe: acceptance of a low synchronized level.
   always_ff @(posedge clk) begin
      if (!rst_btn) begin
         release_pulse <= '0;
      end else begin
         release_pulse <= accept & ~s2;
      end
   end
`else
   assign release_pulse = '0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce (N_BTN=2, DEBOUNCE_CYCLES=4).
// The reference model accepts a new level once the last DEBOUNCE_CYCLES
// synchronized samples all disagree with the current debounced level.
module tb_button_debounce;

   localparam int D = 4;
`ifdef BUTTON_DEBOUNCE_RELEASE_PULSE_EN
   localparam logic RP_EN = 1'b1;
`else
   localparam logic RP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_btn;
   logic [1:0] pmod;
   logic [1:0] pressed;
   logic [1:0] press_pulse;
   logic [1:0] release_pulse;

   int vectors    = 0;
   int miscompares = 0;

   // reference model state
   logic [1:0]   dl [$];
   logic [D-1:0] hist [2];
   int           fill [2];
   logic [1:0]   exp_pressed;
   logic [1:0]   exp_pp;
   logic [1:0]   exp_rp;

   button_debounce #(
      .N_BTN(2),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk(clk),
      .rst_btn(rst_btn),
      .pmod(pmod),
      .pressed(pressed),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      dl.delete();
      dl.push_back(2'b00);
      dl.push_back(2'b00);
      for (int b = 0; b < 2; b++) begin
         hist[b] = '0;
         fill[b] = 0;
      end
      exp_pressed = '0;
      exp_pp      = '0;
      exp_rp      = '0;
   endtask

   task automatic model_edge(input logic [1:0] pm, input logic rst);
      logic [1:0] lvl;
      if (!rst) begin
         model_reset();
      end else begin
         lvl = dl.pop_front();
         dl.push_back(~pm);
         exp_pp = '0;
         exp_rp = '0;
         for (int b = 0; b < 2; b++) begin
            hist[b] = {hist[b][D-2:0], lvl[b]};
            if (fill[b] < D) fill[b]++;
            if (fill[b] == D && hist[b] == {D{~exp_pressed[b]}}) begin
               exp_pressed[b] = ~exp_pressed[b];
               if (exp_pressed[b]) exp_pp[b] = 1'b1;
               else                exp_rp[b] = RP_EN;
            end
         end
      end
   endtask

   task automatic step(input logic [1:0] pm, input logic rst);
      pmod    = pm;
      rst_btn = rst;
      @(posedge clk);
      model_edge(pm, rst);
      #1;
   endtask

   task automatic settle();
      step(2'b11, 1'b0);
      for (int k = 0; k < 3; k++) step(2'b11, 1'b1);
   endtask

   task automatic test_reset();
      for (int e = 1; e <= 3; e++) begin
         step(2'b00, 1'b0);
         vectors++;
         if ({pressed, press_pulse, release_pulse} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_hold edge %0d: got %b want 000000", e,
                     {pressed, press_pulse, release_pulse});
         end
      end
      for (int e = 1; e <= 8; e++) begin
         step(2'b00, 1'b1);
         vectors++;
         if (pressed !== ((e >= 6) ? 2'b11 : 2'b00) ||
             press_pulse !== ((e == 6) ? 2'b11 : 2'b00) || release_pulse !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release edge %0d: got p=%b pp=%b rp=%b", e,
                     pressed, press_pulse, release_pulse);
         end
         vectors++;
         if ({pressed, press_pulse, release_pulse} !== {exp_pressed, exp_pp, exp_rp}) begin
            miscompares++;
            $display("FAIL reset_model edge %0d: got %b want %b", e,
                     {pressed, press_pulse, release_pulse}, {exp_pressed, exp_pp, exp_rp});
         end
      end
   endtask

   task automatic test_clean_press();
      settle();
      for (int e = 1; e <= 8; e++) begin
         step(2'b10, 1'b1);
         vectors++;
         if (pressed !== ((e >= 6) ? 2'b01 : 2'b00) ||
             press_pulse !== ((e == 6) ? 2'b01 : 2'b00) || release_pulse !== 2'b00) begin
            miscompares++;
            $display("FAIL clean_press edge %0d: got p=%b pp=%b rp=%b", e,
                     pressed, press_pulse, release_pulse);
         end
      end
   endtask

   task automatic test_bounce();
      logic [1:0] seq [$];
      settle();
      seq = '{2'b10, 2'b10, 2'b10, 2'b11};
      for (int e = 0; e < 4; e++) begin
         step(seq[e], 1'b1);
         vectors++;
         if ({pressed, press_pulse, release_pulse} !== 6'b0) begin
            miscompares++;
            $display("FAIL bounce_glitch edge %0d: got %b want 000000", e,
                     {pressed, press_pulse, release_pulse});
         end
      end
      for (int e = 1; e <= 8; e++) begin
         step(2'b10, 1'b1);
         vectors++;
         if (pressed !== ((e >= 6) ? 2'b01 : 2'b00) ||
             press_pulse !== ((e == 6) ? 2'b01 : 2'b00)) begin
            miscompares++;
            $display("FAIL bounce_settle edge %0d: got p=%b pp=%b", e, pressed, press_pulse);
         end
      end
   endtask

   task automatic test_release();
      settle();
      for (int e = 1; e <= 8; e++) step(2'b10, 1'b1);
      for (int e = 1; e <= 8; e++) begin
         step(2'b11, 1'b1);
         vectors++;
         if (pressed !== ((e < 6) ? 2'b01 : 2'b00) || press_pulse !== 2'b00 ||
             release_pulse !== ((e == 6) ? {1'b0, RP_EN} : 2'b00)) begin
            miscompares++;
            $display("FAIL release edge %0d: got p=%b pp=%b rp=%b", e,
                     pressed, press_pulse, release_pulse);
         end
      end
   endtask

   task automatic test_simultaneous();
      settle();
      for (int e = 1; e <= 8; e++) begin
         step(2'b00, 1'b1);
         vectors++;
         if (pressed !== ((e >= 6) ? 2'b11 : 2'b00) ||
             press_pulse !== ((e == 6) ? 2'b11 : 2'b00)) begin
            miscompares++;
            $display("FAIL simultaneous edge %0d: got p=%b pp=%b", e, pressed, press_pulse);
         end
      end
   endtask

   task automatic test_reset_mid();
      settle();
      for (int e = 1; e <= 4; e++) step(2'b10, 1'b1);
      step(2'b10, 1'b0);
      vectors++;
      if ({pressed, press_pulse, release_pulse} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_mid_hold: got %b want 000000", {pressed, press_pulse, release_pulse});
      end
      for (int e = 1; e <= 8; e++) begin
         step(2'b10, 1'b1);
         vectors++;
         if (pressed !== ((e >= 6) ? 2'b01 : 2'b00) ||
             press_pulse !== ((e == 6) ? 2'b01 : 2'b00)) begin
            miscompares++;
            $display("FAIL reset_mid edge %0d: got p=%b pp=%b", e, pressed, press_pulse);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] pm;
      int         hold [2];
      logic       rst;
      settle();
      pm   = 2'b11;
      hold = '{0, 0};
      for (int c = 0; c < 2000; c++) begin
         for (int b = 0; b < 2; b++) begin
            if (hold[b] == 0) begin
               pm[b]   = 1'($urandom_range(0, 1));
               hold[b] = int'($urandom_range(1, 2 * D + 2));
            end else begin
               hold[b]--;
            end
         end
         rst = ($urandom_range(0, 199) != 0);
         step(pm, rst);
         vectors++;
         if ({pressed, press_pulse, release_pulse} !== {exp_pressed, exp_pp, exp_rp}) begin
            miscompares++;
            $display("FAIL random cycle %0d: got %b want %b", c,
                     {pressed, press_pulse, release_pulse}, {exp_pressed, exp_pp, exp_rp});
         end
         vectors++;
         if ((press_pulse & release_pulse) !== 2'b00) begin
            miscompares++;
            $display("FAIL random_exclusive cycle %0d: got pp=%b rp=%b want disjoint", c,
                     press_pulse, release_pulse);
         end
      end
   endtask

   initial begin
      rst_btn = 1'b0;
      pmod    = 2'b11;
      model_reset();
      #2;
      test_reset();
      test_clean_press();
      test_bounce();
      test_release();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/button_debounce.md
# button_debounce

Input conditioner for the active-low pushbuttons on the `pmod` header. It is the input-side counterpart to the combinational button-to-LED logic. Each raw button passes through a two-flop synchronizer, then a per-button stability counter. The block outputs a clean active-high `pressed` level plus one-cycle `press_pulse` and `release_pulse` strobes. Downstream counters and LED state machines consume these outputs instead of the raw `pmod` pins.

## Interface

Parameters:
- `N_BTN`, 2: number of buttons handled; one independent channel each.
- `DEBOUNCE_CYCLES`, 120000: number of consecutive clock cycles a new synchronized level must persist before it is accepted. The default is 10 ms at 12 MHz. Legal range is ≥ 1.

Ports:
- `clk`, input, 1: system clock; all flops are on its rising edge.
- `rst_btn`, input, 1: reset, synchronous, active-low.
- `pmod`, input, `N_BTN`: raw pushbuttons, active-low (0 = pressed), asynchronous to `clk`.
- `pressed`, output, `N_BTN`: debounced level, active-high (1 = held).
- `press_pulse`, output, `N_BTN`: one-cycle strobe on each accepted press.
- `release_pulse`, output, `N_BTN`: one-cycle strobe on each accepted release (see Configuration).

## Operation

Synchronizer:
- Per button, `s1 <= ~pmod[i]`, then `s2 <= s1`.
- Inversion happens at the synchronizer input, so `s2` is active-high.

Debounce counter:
- One counter per button, width `$clog2(DEBOUNCE_CYCLES+1)`, unsigned.
- Each cycle, when `s2[i] == pressed[i]`: set `cnt[i] <= 0`.
- Each cycle, when `s2[i] != pressed[i]` and `cnt[i] != DEBOUNCE_CYCLES-1`: set `cnt[i] <= cnt[i]+1`.
- Each cycle, when `s2[i] != pressed[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: set `pressed[i] <= s2[i]` and `cnt[i] <= 0`. Fire the strobe matching the new level.
- Any single cycle where `s2` returns to the current `pressed` value restarts the count. A bounce therefore never produces a strobe.
- The counter never wraps. The maximum value held is `DEBOUNCE_CYCLES-1`.

Per-button states (implicit in `pressed` and `cnt`):
- RELEASED_STABLE (`pressed=0`, `cnt=0`) → RELEASED_COUNTING on `s2=1`.
- RELEASED_COUNTING → RELEASED_STABLE on `s2=0`.
- RELEASED_COUNTING → PRESSED_STABLE on terminal count; `press_pulse` fires.
- The pressed side is symmetric. Reaching RELEASED_STABLE from the pressed side fires `release_pulse`.

Strobes:
- `press_pulse[i]` and `release_pulse[i]` are registered and high for exactly one cycle.
- They assert in the same cycle that `pressed[i]` changes.
- The two strobes for the same button are never high together.

Channels are fully independent. Simultaneous events on different buttons produce strobes in the same cycle.

Reset, when `rst_btn=0` at a clock edge:
- `s1`, `s2`, `cnt` clear to 0.
- `pressed`, `press_pulse`, `release_pulse` clear to 0.
- Reset overrides any in-progress count.
- A button held through reset is treated as a new press once reset releases. It fires `press_pulse` after the full latency.

## Timing

- Latency: edge 1 is the first rising edge that samples the new `pmod` level into `s1`. `pressed` and the strobe are visible after edge `DEBOUNCE_CYCLES+2`.
  - 2 edges are synchronizer.
  - `DEBOUNCE_CYCLES` edges are stability counting.
- Minimum accepted pulse width: `DEBOUNCE_CYCLES` consecutive cycles at `s2`. Anything shorter is filtered.
- No combinational path from any input to any output; all outputs come directly from flops.
- Throughput: one level change per button at most every `DEBOUNCE_CYCLES` cycles.

## Configuration

- `BUTTON_DEBOUNCE_RELEASE_PULSE_EN` defined:
  - `release_pulse[i]` fires one cycle on each accepted 1→0 transition of `pressed[i]`.
- `BUTTON_DEBOUNCE_RELEASE_PULSE_EN` undefined:
  - The `release_pulse` port remains, tied to constant 0.
  - No release strobe logic is synthesized.
  - `pressed` and `press_pulse` behaviour is unchanged.

## Test plan

All scenarios use `N_BTN=2`, `DEBOUNCE_CYCLES=4`.

- Reset with buttons held: `pmod=2'b00`, `rst_btn=0` for 3 edges → all outputs 0 during reset. After release, `pressed=2'b11` and `press_pulse=2'b11` for one cycle at the 6th edge.
- Clean press: `pmod[0]` 1→0 and held, `pmod[1]=1` → `pressed[0]` rises at the 6th edge, `press_pulse[0]` high for exactly that cycle. `pressed[1]`, `press_pulse[1]` and all `release_pulse` bits stay 0.
- Bounce: `pmod[0]` low 3 cycles, high 1 cycle, then low steady → no strobe during the glitch. `pressed[0]` rises 6 edges after the final falling edge.
- Release: release `pmod[0]` after an accepted press → `pressed[0]` falls at the 6th edge.
  - With macro: `release_pulse[0]=1` for one cycle.
  - Without macro: `release_pulse` stays 2'b00 throughout.
- Simultaneous: both buttons fall on the same edge → `press_pulse=2'b11` in a single cycle, 6 edges later.
- Reset mid-count: `pmod[0]` low, assert `rst_btn=0` when `cnt[0]=2`, release after 1 edge → `pressed[0]` stays 0. It rises only 6 edges after reset release.
